// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ctrl
// Description : Buffered serial-port controller. Sits between the device
//               controller register bus and the UART receiver/transmitter.
//               Holds an RX FIFO fed by the receiver and a TX FIFO drained
//               autonomously into the transmitter by a small FSM. Exposes a
//               DATA / STATUS / CONTROL register map, sticky rxOverrun and
//               txOverflow flags and a registered interrupt request.
// Ports       : clk25, rst (sync, active-high)
//               enable_i, readEnable_i, addr_i, dataSave_i -> register access
//               dataLoad_o                                 <- read data (comb)
//               int_o                                      <- interrupt request
//               rxdReady_i, rxdData_i                      -> receiver byte
//               txdBusy_i                                  -> transmitter busy
//               txdStart_o, txdData_o                      <- transmitter start
// Options     : UART_FIFO_LOOPBACK_EN builds the CONTROL bit2 loopback path
//               (TX bytes are routed into RX instead of the transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
    parameter int RX_DEPTH_LOG2    = 4,
    parameter int TX_DEPTH_LOG2    = 4,
    parameter int RX_INT_THRESHOLD = 1
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);

    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_CW    = RX_DEPTH_LOG2 + 1;
    localparam int TX_CW    = TX_DEPTH_LOG2 + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [7:0]               rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0]         rx_count;
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0]         tx_count;

    logic       rx_overrun, tx_overflow;
    logic       rx_int_en, tx_int_en, loopback;
    logic [1:0] state, state_next;

    logic       wr_data, rd_data, wr_status, wr_control;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0] rx_head, tx_head;
    logic       rx_push_req, rx_push, rx_pop;
    logic [7:0] rx_push_data;
    logic       tx_push, tx_pop, tx_launch, tx_loop;
    logic       unused_data_bits;

    assign wr_data    = enable_i & ~readEnable_i & (addr_i == ADDR_DATA);
    assign rd_data    = enable_i &  readEnable_i & (addr_i == ADDR_DATA);
    assign wr_status  = enable_i & ~readEnable_i & (addr_i == ADDR_STATUS);
    assign wr_control = enable_i & ~readEnable_i & (addr_i == ADDR_CONTROL);

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign rx_head  = rx_mem[rx_rd_ptr];
    assign tx_head  = tx_mem[tx_rd_ptr];

    // Only the low byte of DATA writes and a few STATUS/CONTROL bits matter.
    assign unused_data_bits = ^dataSave_i[31:8];

    // In loopback the drain FSM is the only RX source; receiver pulses are ignored.
    assign rx_pop       = rd_data & ~rx_empty;
    assign rx_push_req  = loopback ? tx_loop : rxdReady_i;
    assign rx_push_data = loopback ? tx_head : rxdData_i;
    // A full FIFO still accepts a push when it pops in the same cycle.
    assign rx_push      = rx_push_req & (~rx_full | rx_pop);

    assign tx_pop  = tx_launch | tx_loop;
    assign tx_push = wr_data & (~tx_full | tx_pop);

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk25) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= dataSave_i[7:0];
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
            rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
            tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end
    end

    // ---------------- Sticky flags and control bits ----------------
    // A new drop in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            rx_int_en   <= 1'b1;
            tx_int_en   <= 1'b0;
        end else begin
            if (wr_status && dataSave_i[4]) rx_overrun <= 1'b0;
            if (rx_push_req && rx_full && !rx_pop) rx_overrun <= 1'b1;
            if (wr_status && dataSave_i[5]) tx_overflow <= 1'b0;
            if (wr_data && tx_full && !tx_pop) tx_overflow <= 1'b1;
            if (wr_control) begin
                rx_int_en <= dataSave_i[0];
                tx_int_en <= dataSave_i[1];
            end
        end
    end

`ifdef UART_FIFO_LOOPBACK_EN
    always_ff @(posedge clk25) begin
        if (rst)             loopback <= 1'b0;
        else if (wr_control) loopback <= dataSave_i[2];
    end
`else
    assign loopback = 1'b0;
`endif

    // ---------------- TX drain FSM ----------------
    always_ff @(posedge clk25) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (!tx_empty && !loopback && !txdBusy_i) state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (txdBusy_i)  state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!txdBusy_i) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Loopback moves one byte per cycle straight into RX without leaving IDLE.
    always_comb begin
        tx_launch = 1'b0;
        tx_loop   = 1'b0;
        if (state == S_IDLE && !tx_empty) begin
            if (loopback)        tx_loop   = 1'b1;
            else if (!txdBusy_i) tx_launch = 1'b1;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            txdStart_o <= 1'b0;
            txdData_o  <= 8'h00;
            int_o      <= 1'b0;
        end else begin
            txdStart_o <= tx_launch;
            if (tx_launch) txdData_o <= tx_head;
            int_o <= (rx_int_en & (rx_count >= RX_CW'(RX_INT_THRESHOLD)))
                   | (tx_int_en & tx_empty & (state == S_IDLE));
        end
    end

    // ---------------- Read data ----------------
    always_comb begin
        dataLoad_o = '0;
        case (addr_i)
            ADDR_DATA: if (!rx_empty) dataLoad_o[7:0] = rx_head;
            ADDR_STATUS: begin
                dataLoad_o[0]     = ~rx_empty;
                dataLoad_o[1]     = ~tx_full;
                dataLoad_o[2]     = rx_full;
                dataLoad_o[3]     = tx_empty;
                dataLoad_o[4]     = rx_overrun;
                dataLoad_o[5]     = tx_overflow;
                dataLoad_o[15:8]  = 8'(rx_count);
                dataLoad_o[23:16] = 8'(tx_count);
            end
            ADDR_CONTROL: begin
                dataLoad_o[0] = rx_int_en;
                dataLoad_o[1] = tx_int_en;
                dataLoad_o[2] = loopback;
            end
            default: dataLoad_o = '0;
        endcase
    end

endmodule
`default_nettype wire
